// File: rtl/moore_seq_pkg.sv
// Shared definitions for the Moore sequence transmitter/detector family:
// state encoding, common pattern constants and a width helper.
package moore_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } seq_state_e;

    localparam logic [3:0] DEF_PAT_1011 = 4'b1011;

    // Minimum of 1 bit so a counter always has a legal width.
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/moore_pattern_tx_if.sv
// Control/data bundle between a pattern transmitter (slave) and the block
// that configures and triggers it (master).
interface moore_pattern_tx_if #(
    parameter int PAT_W = 4,
    parameter int REP_W = 8
);
    logic             pat_load;
    logic [PAT_W-1:0] pat_in;
    logic             start;
    logic [REP_W-1:0] rep_cnt;
    logic             out;
    logic             out_valid;
    logic             busy;
    logic             done;

    modport master (
        output pat_load, pat_in, start, rep_cnt,
        input  out, out_valid, busy, done
    );

    modport slave (
        input  pat_load, pat_in, start, rep_cnt,
        output out, out_valid, busy, done
    );
endinterface

// File: rtl/pattern_shreg.sv
// Parallel-load, left-shift register presenting its MSB; load has priority
// over shift so a reload can coincide with the final shift of a copy.
module pattern_shreg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [W-1:0] din,
    output logic         msb
);
    logic [W-1:0] q;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[W-2:0], 1'b0};
        end
    end

    assign msb = q[W-1];
endmodule

// File: rtl/moore_pattern_tx.sv
// Moore serial pattern transmitter: sends a stored pattern MSB first, a
// programmable number of times, with a fixed idle gap between copies.
//
// state | meaning
// IDLE  | waiting for start; pattern register may be reloaded
// SEND  | shifting the current copy out, one bit per clock
// GAP   | idle spacing between copies, GAP_CYC cycles
// DONE  | one-cycle completion pulse before returning to IDLE
module moore_pattern_tx
    import moore_seq_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] DEF_PAT = DEF_PAT_1011,
    parameter int               GAP_CYC = 2,
    parameter int               REP_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    moore_pattern_tx_if.slave     bus
);
    localparam int               BW       = clog2(PAT_W);
    localparam logic [BW-1:0]    BIT_LAST = BW'(PAT_W - 1);
    localparam logic [3:0]       GAP_LAST = (GAP_CYC > 0) ? 4'(GAP_CYC - 1) : 4'd0;

    seq_state_e       state, state_nx;
    logic [PAT_W-1:0] pat_q, pat_nx;
    logic [BW-1:0]    bit_q, bit_nx;
    logic [REP_W-1:0] rep_q, rep_nx;
    logic [3:0]       gap_q, gap_nx;
    logic             sh_load, sh_shift, sh_msb;
    logic [PAT_W-1:0] sh_din;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pat_q <= DEF_PAT;
            bit_q <= '0;
            rep_q <= '0;
            gap_q <= '0;
        end else begin
            state <= state_nx;
            pat_q <= pat_nx;
            bit_q <= bit_nx;
            rep_q <= rep_nx;
            gap_q <= gap_nx;
        end
    end

    always_comb begin
        state_nx = state;
        pat_nx   = pat_q;
        bit_nx   = bit_q;
        rep_nx   = rep_q;
        gap_nx   = gap_q;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        sh_din   = pat_q;
        case (state)
            IDLE: begin
                // A load arriving with start is also the pattern for this frame.
                if (bus.pat_load) begin
                    pat_nx = bus.pat_in;
                end
                if (bus.start) begin
                    sh_load  = 1'b1;
                    sh_din   = bus.pat_load ? bus.pat_in : pat_q;
                    rep_nx   = (bus.rep_cnt == '0) ? '0 : bus.rep_cnt - REP_W'(1);
                    bit_nx   = BIT_LAST;
                    state_nx = SEND;
                end
            end
            SEND: begin
                sh_shift = 1'b1;
                if (bit_q != '0) begin
                    bit_nx = bit_q - BW'(1);
                end else if (rep_q != '0) begin
                    rep_nx = rep_q - REP_W'(1);
                    if (GAP_CYC == 0) begin
                        sh_load = 1'b1;
                        bit_nx  = BIT_LAST;
                    end else begin
                        gap_nx   = GAP_LAST;
                        state_nx = GAP;
                    end
                end else begin
                    state_nx = DONE;
                end
            end
            GAP: begin
                if (gap_q == '0) begin
                    sh_load  = 1'b1;
                    bit_nx   = BIT_LAST;
                    state_nx = SEND;
                end else begin
                    gap_nx = gap_q - 4'd1;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    pattern_shreg #(.W(PAT_W)) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (sh_load),
        .shift (sh_shift),
        .din   (sh_din),
        .msb   (sh_msb)
    );

    assign bus.out       = (state == SEND) & sh_msb;
    assign bus.out_valid = (state == SEND);
    assign bus.busy      = (state != IDLE);
    assign bus.done      = (state == DONE);
endmodule

// File: tb/tb_moore_pattern_tx.sv
// Bench for moore_pattern_tx: directed scenarios plus random traffic, each
// cycle compared against a queue-based model of the expected output stream.
module tb_moore_pattern_tx;
    import moore_seq_pkg::*;

    localparam int PAT_W   = 4;
    localparam int REP_W   = 8;
    localparam int GAP_CYC = 2;
    localparam logic [PAT_W-1:0] DEF = 4'b1011;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    moore_pattern_tx_if #(.PAT_W(PAT_W), .REP_W(REP_W)) bus ();

    moore_pattern_tx #(
        .PAT_W   (PAT_W),
        .DEF_PAT (DEF),
        .GAP_CYC (GAP_CYC),
        .REP_W   (REP_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: each entry is one cycle of {busy, done, out_valid, out}.
    logic [3:0]       mq[$];
    logic [3:0]       m_cur = 4'b0000;
    logic [PAT_W-1:0] m_pat = DEF;

    always @(posedge clk) begin
        logic [PAT_W-1:0] p;
        int n;
        if (rst) begin
            mq.delete();
            m_cur = 4'b0000;
            m_pat = DEF;
        end else begin
            if (!m_cur[3]) begin
                if (bus.pat_load) m_pat = bus.pat_in;
                if (bus.start) begin
                    p = m_pat;
                    n = (bus.rep_cnt == 0) ? 1 : int'(bus.rep_cnt);
                    for (int c = 0; c < n; c++) begin
                        for (int i = PAT_W - 1; i >= 0; i--) mq.push_back({3'b101, p[i]});
                        if (c < n - 1) for (int g = 0; g < GAP_CYC; g++) mq.push_back(4'b1000);
                    end
                    mq.push_back(4'b1100);
                end
            end
            m_cur = (mq.size() > 0) ? mq.pop_front() : 4'b0000;
        end
    end

    int busy_n, done_n, valid_n, idle_n, hits, since;
    logic [15:0] rx;
    logic [3:0]  win;

    task automatic clr();
        busy_n = 0; done_n = 0; valid_n = 0; idle_n = 0; hits = 0; since = 0;
        rx = '0; win = '0;
    endtask

    // Advance one clock and check the outputs mid-cycle.
    task automatic step();
        logic [3:0] obs;
        @(negedge clk);
        obs = {bus.busy, bus.done, bus.out_valid, bus.out};
        chk("cycle", {28'b0, obs}, {28'b0, m_cur});
        if (obs[3]) busy_n++; else idle_n++;
        if (obs[2]) done_n++;
        if (obs[1]) begin
            valid_n++;
            rx  = {rx[14:0], obs[0]};
            win = {win[2:0], obs[0]};
            since++;
            if (win == 4'b1011 && since >= 4) begin
                hits++;
                since = 0;
            end
        end
    endtask

    task automatic run_idle(input int maxc);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (bus.busy && k < maxc);
        chk("idle_timeout", {31'b0, bus.busy}, 32'd0);
    endtask

    task automatic send(input logic [3:0] pat, input logic ld, input int rep);
        bus.start    = 1'b1;
        bus.pat_load = ld;
        bus.pat_in   = pat;
        bus.rep_cnt  = REP_W'(rep);
        step();
        bus.start    = 1'b0;
        bus.pat_load = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.pat_load = 1'b0; bus.pat_in = '0; bus.rep_cnt = '0;
        clr();
        step(); step();
        chk("reset_outs", {28'b0, bus.busy, bus.done, bus.out_valid, bus.out}, 32'd0);
        rst = 1'b0;
        step();

        // Single copy of the default pattern.
        clr(); send(4'b0000, 1'b0, 1); run_idle(20);
        chk("t1_bits", {28'b0, rx[3:0]}, 32'hB);
        chk("t1_busy", busy_n, 5);
        chk("t1_done", done_n, 1);

        // Three copies separated by gaps.
        clr(); send(4'b0000, 1'b0, 3); run_idle(40);
        chk("t2_busy", busy_n, 17);
        chk("t2_valid", valid_n, 12);
        chk("t2_hits", hits, 3);
        chk("t2_done", done_n, 1);

        // Load in IDLE, rep_cnt of zero sends one copy; load persists.
        bus.pat_load = 1'b1; bus.pat_in = 4'b0110; step(); bus.pat_load = 1'b0;
        clr(); send(4'b0000, 1'b0, 0); run_idle(20);
        chk("t3_bits", {28'b0, rx[3:0]}, 32'h6);
        chk("t3_valid", valid_n, 4);
        clr(); send(4'b0000, 1'b0, 1); run_idle(20);
        chk("t3_again", {28'b0, rx[3:0]}, 32'h6);

        // Load while busy is ignored.
        clr(); send(4'b0000, 1'b0, 1);
        bus.pat_load = 1'b1; bus.pat_in = 4'b1100; step(); bus.pat_load = 1'b0;
        run_idle(20);
        chk("t4_cur", {28'b0, rx[3:0]}, 32'h6);
        clr(); send(4'b0000, 1'b0, 1); run_idle(20);
        chk("t4_next", {28'b0, rx[3:0]}, 32'h6);

        // Reset during the second bit abandons the frame and restores DEF.
        clr(); send(4'b0000, 1'b0, 1); step();
        rst = 1'b1; step();
        chk("t5_rst_outs", {28'b0, bus.busy, bus.done, bus.out_valid, bus.out}, 32'd0);
        rst = 1'b0;
        clr(); send(4'b0000, 1'b0, 1); run_idle(20);
        chk("t5_def", {28'b0, rx[3:0]}, 32'hB);

        // Start held high: one IDLE cycle between back-to-back frames.
        clr();
        bus.start = 1'b1; bus.rep_cnt = 8'd1;
        repeat (18) step();
        bus.start = 1'b0;
        chk("t6_done", done_n, 3);
        chk("t6_idle", idle_n, 3);
        chk("t6_valid", valid_n, 12);
        chk("t6_bits", {20'b0, rx[11:0]}, 32'hBBB);
        run_idle(20);

        // Random traffic against the model.
        clr();
        repeat (3000) begin
            rst          = ($urandom_range(0, 149) == 0);
            bus.start    = ($urandom_range(0, 3) == 0);
            bus.pat_load = ($urandom_range(0, 4) == 0);
            bus.pat_in   = PAT_W'($urandom);
            bus.rep_cnt  = REP_W'($urandom_range(0, 4));
            step();
        end
        rst = 1'b0; bus.start = 1'b0; bus.pat_load = 1'b0;
        run_idle(200);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/moore_pattern_tx.md
Name: moore_pattern_tx

Overview:
- Moore-style serial pattern transmitter. It is the source side of the team's Moore sequence detectors.
- On a start request it serially emits a programmable PAT_W-bit pattern, MSB first, one bit per clock.
- The pattern is sent a programmable number of times, with a fixed idle gap between copies.
- Used as the on-chip stimulus source for the detector lab blocks and as a standalone framing transmitter.

Parameters:
- PAT_W, 4, pattern width in bits (2..16).
- DEF_PAT, 4'b1011, pattern loaded at reset.
- GAP_CYC, 2, idle cycles between repetitions (0..15; 0 = back-to-back).
- REP_W, 8, width of the repeat-count input.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pat_load  in  1  load pat_in into the pattern register; honoured only in IDLE.
- pat_in  in  PAT_W  new pattern value.
- start  in  1  start request; honoured only in IDLE.
- rep_cnt  in  REP_W  number of pattern copies; sampled with start; 0 is treated as 1.
- out  out  1  serial data bit.
- out_valid  out  1  high while out carries a pattern bit.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last bit of the last copy.

Behaviour:
- Reset (synchronous): state=IDLE, pattern register=DEF_PAT, bit counter=0, rep counter=0. Outputs: out=0, out_valid=0, busy=0, done=0.
- All outputs are Moore. They are decoded from registered state and registers only; there is no combinational path from any input to any output.
- IDLE:
  - If pat_load=1 and start=0: pattern register takes pat_in; stay in IDLE.
  - If start=1: shift register takes the pattern register (or pat_in if pat_load is also 1, i.e. load wins and is used for this frame). Rep counter takes max(rep_cnt,1)-1, bit counter takes PAT_W-1, next state=SEND.
  - pat_load and start outside IDLE are ignored, with no latching.
- SEND:
  - out = shift register MSB, out_valid=1, busy=1.
  - Each cycle the register shifts left by 1 and the bit counter decrements.
  - When bit counter=0 (last bit on out):
    - If rep counter>0: rep counter decrements; next state=GAP (or straight back into SEND with a reloaded shift register if GAP_CYC=0).
    - Else next state=DONE.
- GAP:
  - out=0, out_valid=0, busy=1, for exactly GAP_CYC cycles (gap counter).
  - Then the shift register reloads from the pattern register, bit counter=PAT_W-1, next state=SEND.
- DONE: done=1, busy=1, out=0, out_valid=0 for exactly one cycle; next state=IDLE.
- Latency:
  - start seen high at edge k gives the first bit on out in the cycle after edge k.
  - A frame occupies PAT_W cycles of out_valid.
  - Total busy cycles = N*PAT_W + (N-1)*GAP_CYC + 1, where N = max(rep_cnt,1).
- Start held high through DONE: a new frame begins only from IDLE, so there is at least one IDLE cycle between frames.
- Reset asserted mid-frame: the frame is abandoned; next cycle all outputs are at reset values and the pattern register returns to DEF_PAT.
- Illegal or unused state encodings go to IDLE.
- Counter widths:
  - bit counter: clog2(PAT_W).
  - gap counter: 4 bits.
  - rep counter: REP_W. rep counter never wraps; the decrement is gated by >0.

Decomposition:
- Shared package moore_seq_pkg holds:
  - the state enum (IDLE, SEND, GAP, DONE, 2-bit encoding);
  - DEF_PAT_1011 = 4'b1011;
  - the clog2 helper.
- The detector blocks reuse the same package for pattern constants.
- One sub-module is natural: pattern_shreg. It is a PAT_W-bit parallel-load, left-shift register with MSB output, controlled by load and shift enables.

Test Plan:
- Reset, then start=1 for 1 cycle with rep_cnt=1 -> out = 1,0,1,1 with out_valid=1 for 4 cycles; done pulses on cycle 5; busy high for 5 cycles.
- rep_cnt=3, GAP_CYC=2 -> three copies of 1011, each followed by 2 cycles of out_valid=0 except after the last; busy high for 3*4+2*2+1=17 cycles. A non-overlapping 1011 detector fed by out fires exactly 3 times.
- pat_load=1 with pat_in=4'b0110 in IDLE, then start with rep_cnt=0 -> a single copy 0,1,1,0 (0 treated as 1); a later start without load again sends 0110.
- pat_load=1 with pat_in=4'b1100 while busy -> ignored; current and next frames still use the old pattern.
- rst=1 during the second bit of a frame -> next cycle out=0, out_valid=0, busy=0, done=0; a following start sends DEF_PAT 1011.
- start held high continuously with rep_cnt=1 -> frames separated by exactly one IDLE cycle after each done; no bit is lost or duplicated.
